// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and helpers for the register-file dump path.
//               It holds the dumper FSM state encoding, the stream byte width
//               and the address-width function. The dumper and the register
//               file both use that function, so their AW values always match.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int BYTE_W = 8;

    // Index width for a register file of reg_count entries (at least 1 bit).
    function automatic int addr_width(input int reg_count);
        return (reg_count > 1) ? $clog2(reg_count) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dumper_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_serializer
// Description : Loads one REG_WIDTH word and emits it least-significant byte
//               first on an 8-bit valid/ready stream. It flags the byte that
//               ends the word, and the byte that ends the whole dump when the
//               loaded word is the final one.
// Revision    : 1.0 - initial release
// ============================================================================
module word_serializer
    import regfile_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [REG_WIDTH-1:0] load_data_i,
    input  logic                 last_word_i,
    output logic [BYTE_W-1:0]    data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic                 word_done_o
);

    localparam int BYTES = REG_WIDTH / BYTE_W;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    logic [REG_WIDTH-1:0] shreg_q;
    logic [IW-1:0]        idx_q;
    logic                 valid_q;
    logic                 last_word_q;
    logic                 hs;
    logic                 final_byte;

    assign hs         = valid_q & ready_i;
    assign final_byte = (idx_q == LAST_IDX);

    // Snapshot the word on load, then step one byte per accepted handshake.
    // valid stays up from load until the last byte is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            last_word_q <= 1'b0;
        end else if (load_i) begin
            shreg_q     <= load_data_i;
            idx_q       <= '0;
            valid_q     <= 1'b1;
            last_word_q <= last_word_i;
        end else if (hs) begin
            if (!final_byte) begin
                shreg_q <= shreg_q >> BYTE_W;
                idx_q   <= idx_q + 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o      = shreg_q[BYTE_W-1:0];
    assign valid_o     = valid_q;
    assign last_o      = valid_q & last_word_q & final_byte;
    assign word_done_o = hs & final_byte;

endmodule
`default_nettype wire

// File: rtl/regfile_dumper.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dumper
// Description : Walks a contiguous, wrapping range of registers through one
//               asynchronous read port. Each word is serialized as a
//               little-endian byte stream with valid/ready handshaking. A
//               done pulse follows the final byte.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dumper
    import regfile_pkg::*;
#(
    parameter  int REG_WIDTH = 32,
    parameter  int REG_COUNT = 16,
    localparam int AW        = addr_width(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        first_addr,
    input  logic [AW:0]          count,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        rd_addr,
    input  logic [REG_WIDTH-1:0] rd_data,
    output logic [BYTE_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(REG_COUNT - 1);
    localparam logic [AW:0]   ONE_LEFT  = {{AW{1'b0}}, 1'b1};

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   remaining_q;
    logic          load;
    logic          last_word;
    logic          word_done;

    assign load      = (state_q == FETCH);
    assign last_word = (remaining_q == ONE_LEFT);

    // Sequencer: latch the range on start, then alternate FETCH/SEND per word.
    // addr_q wraps modulo REG_COUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            addr_q      <= first_addr;
                            remaining_q <= count;
                            state_q     <= FETCH;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                FETCH: state_q <= SEND;
                SEND: begin
                    if (word_done) begin
                        if (last_word) begin
                            state_q <= DONE;
                        end else begin
                            addr_q      <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                            remaining_q <= remaining_q - 1'b1;
                            state_q     <= FETCH;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign rd_addr = addr_q;

    word_serializer #(
        .REG_WIDTH (REG_WIDTH)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .load_data_i (rd_data),
        .last_word_i (last_word),
        .data_o      (out_data),
        .valid_o     (out_valid),
        .ready_i     (out_ready),
        .last_o      (out_last),
        .word_done_o (word_done)
    );

endmodule
`default_nettype wire
